// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the 4:1 mux round-robin arbiter.
//   N_REQ   : number of requesters
//   SEL_W   : width of the mux select / requester index
//   state_e : arbiter FSM state codes (spare codes fall back to ST_IDLE)
package mux4_rr_arbiter_pkg;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned SEL_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GRANT = 2'b01
    } state_e;

endpackage

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational rotate-priority picker.
// Scans req starting just after 'last' and wrapping around, so the most
// recent owner has the lowest priority.
//   req   in  N_REQ  request vector
//   last  in  SEL_W  index of the most recent owner
//   found out 1      at least one request is set
//   idx   out SEL_W  index of the winning request (0 when none)
module mux4_rr_arbiter_rr_pick4
    import mux4_rr_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] last,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] k;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        k     = '0;
        // i == N_REQ wraps to last itself, so the previous owner is checked last.
        for (int i = 1; i <= int'(N_REQ); i++) begin
            k = last + SEL_W'(i);
            if (!found && req[k]) begin
                found = 1'b1;
                idx   = k;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter and select controller for a shared 4:1 multiplexer.
// Grants one requester at a time, drives the mux select to the owner index,
// bounds the hold time and inserts a one-cycle dead gap on every handoff.
//   clk   in  1  clock, rising edge
//   rst_n in  1  asynchronous active-low reset
//   en    in  1  allow new grants (an active grant is unaffected)
//   req   in  4  level requests, held until done
//   gnt   out 4  registered one-hot grant, zero when idle
//   s     out 2  mux select; holds the last owner while idle
//   busy  out 1  grant active (== |gnt)
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16, // 0 = unlimited hold
    parameter int unsigned HOLD_W   = 5   // MAX_HOLD must be < 2**HOLD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] s,
    output logic             busy
);

    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    state_e            state_q, state_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [SEL_W-1:0]  s_q, s_d;
    logic [SEL_W-1:0]  last_q, last_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;
    logic             hold_limit;
    logic             hold_sat;

    mux4_rr_arbiter_rr_pick4 u_pick (
        .req   (req),
        .last  (last_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign hold_limit = (MAX_HOLD != 0) && (hold_q == HOLD_MAX);
    // Unlimited mode has no release point, so just stop the counter at all-ones.
    assign hold_sat   = (MAX_HOLD == 0) ? (hold_q == '1) : (hold_q == HOLD_MAX);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        s_d     = s_q;
        last_d  = last_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE: begin
                gnt_d = '0;
                if (en && pick_found) begin
                    state_d = ST_GRANT;
                    gnt_d   = N_REQ'(1) << pick_idx;
                    s_d     = pick_idx;
                    last_d  = pick_idx;
                    hold_d  = HOLD_W'(1);
                end
            end
            ST_GRANT: begin
                // Release always goes through IDLE, which creates the dead gap.
                if (!req[s_q] || hold_limit) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    hold_d  = '0;
                end else if (!hold_sat) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            s_q     <= '0;
            last_q  <= SEL_W'(N_REQ - 1);
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            s_q     <= s_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

    assign gnt  = gnt_q;
    assign s    = s_q;
    assign busy = |gnt_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: four instances (MAX_HOLD = 16, 2, 4, 0) share
// the same stimulus and are compared every cycle against a per-instance
// ownership model (owner, cycles held, last owner).
module tb_mux4_rr_arbiter;

    localparam int N_DUT = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] req;

    logic [3:0] gnt_w  [N_DUT];
    logic [1:0] s_w    [N_DUT];
    logic       busy_w [N_DUT];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        localparam int unsigned MH = (g == 0) ? 16 : (g == 1) ? 2 : (g == 2) ? 4 : 0;
        mux4_rr_arbiter #(
            .MAX_HOLD (MH),
            .HOLD_W   (5)
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (en),
            .req   (req),
            .gnt   (gnt_w[g]),
            .s     (s_w[g]),
            .busy  (busy_w[g])
        );
    end

    int mh        [N_DUT] = '{16, 2, 4, 0};
    int owner     [N_DUT];
    int held      [N_DUT];
    int last      [N_DUT];
    int sel       [N_DUT];
    int prev_s    [N_DUT];
    bit prev_busy [N_DUT];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N_DUT; i++) begin
            owner[i]     = -1;
            held[i]      = 0;
            last[i]      = 3;
            sel[i]       = 0;
            prev_busy[i] = 1'b0;
        end
    endfunction

    // One rising edge with the currently applied en/req.
    function automatic void model_step();
        for (int i = 0; i < N_DUT; i++) begin
            if (owner[i] < 0) begin
                if (en && req != 4'b0000) begin
                    for (int j = 1; j <= 4; j++) begin
                        int k;
                        k = (last[i] + j) % 4;
                        if (req[k]) begin
                            owner[i] = k;
                            held[i]  = 1;
                            last[i]  = k;
                            sel[i]   = k;
                            break;
                        end
                    end
                end
            end else if (!req[owner[i]] || (mh[i] != 0 && held[i] >= mh[i])) begin
                owner[i] = -1;
                held[i]  = 0;
            end else begin
                held[i]++;
            end
        end
    endfunction

    task automatic check_all();
        for (int i = 0; i < N_DUT; i++) begin
            int exp_g;
            exp_g = (owner[i] < 0) ? 0 : (1 << owner[i]);
            check($sformatf("gnt%0d", i), int'(gnt_w[i]), exp_g);
            check($sformatf("s%0d", i), int'(s_w[i]), sel[i]);
            check($sformatf("busy%0d", i), int'(busy_w[i]), (owner[i] >= 0) ? 1 : 0);
            check($sformatf("onehot%0d", i), int'($onehot0(gnt_w[i])), 1);
            check($sformatf("busy_eq_or%0d", i), int'(busy_w[i] == (|gnt_w[i])), 1);
            if (prev_busy[i] && busy_w[i])
                check($sformatf("s_stable%0d", i), int'(s_w[i]), prev_s[i]);
            prev_busy[i] = busy_w[i];
            prev_s[i]    = int'(s_w[i]);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) cycle();
    endtask

    // Called at a falling edge; pulses reset well away from the rising edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #1;
        rst_n = 1'b1;
    endtask

    int exp_rot [5] = '{0, 1, 2, 3, 0};
    int rot_q   [$];

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        req   = 4'b0000;
        model_reset();
        @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // Async reset in the middle of a grant.
        en  = 1'b1;
        req = 4'b0100;
        run(2);
        @(posedge clk);
        model_step();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        rst_n = 1'b1;
        @(negedge clk);
        req = 4'b0000;
        run(2);

        // Single requester, then drop.
        do_reset();
        req = 4'b0010;
        run(4);
        req = 4'b0000;
        run(3);

        // Full rotation; collect grant starts of the MAX_HOLD=2 instance.
        do_reset();
        req = 4'b1111;
        for (int c = 0; c < 15; c++) begin
            bit was_busy;
            was_busy = busy_w[1];
            cycle();
            if (busy_w[1] && !was_busy) rot_q.push_back(int'(s_w[1]));
        end
        check("rot_len", rot_q.size(), 5);
        for (int i = 0; i < 5 && i < rot_q.size(); i++)
            check($sformatf("rot_owner%0d", i), rot_q[i], exp_rot[i]);

        // Preemption by hold limit, then a second requester joins.
        do_reset();
        req = 4'b0001;
        run(10);
        req = 4'b0101;
        run(12);

        // Enable gating.
        do_reset();
        en  = 1'b0;
        req = 4'b1000;
        run(10);
        en = 1'b1;
        run(3);

        // Long hold.
        do_reset();
        req = 4'b0100;
        run(100);
        check("unlimited_hold", int'(gnt_w[3]), 4);

        // Randomized traffic with occasional resets.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 199) == 0) do_reset();
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
